// File: rtl/lipsi_ctrl_if.sv
// Handshake/bus bundle between the Lipsi control FSM (master) and its datapath
// and memories (slave).
interface lipsi_ctrl_if #(
    parameter int PC_W = 8
);
    logic            start;
    logic [PC_W-1:0] pmem_addr;
    logic [7:0]      pmem_rdata;
    logic [7:0]      dmem_addr;
    logic            dmem_re;
    logic            dmem_we;
    logic [7:0]      dmem_rdata;
    logic            acc_zero;
    logic            carry;
    logic [7:0]      imm;
    logic [2:0]      alu_op;
    logic [1:0]      acc_sel;
    logic            acc_we;
    logic            carry_we;
    logic            busy;
    logic            halted;
    logic            illegal;

    modport master (
        input  start, pmem_rdata, dmem_rdata, acc_zero, carry,
        output pmem_addr, dmem_addr, dmem_re, dmem_we, imm, alu_op,
               acc_sel, acc_we, carry_we, busy, halted, illegal
    );

    modport slave (
        output start, pmem_rdata, dmem_rdata, acc_zero, carry,
        input  pmem_addr, dmem_addr, dmem_re, dmem_we, imm, alu_op,
               acc_sel, acc_we, carry_we, busy, halted, illegal
    );
endinterface

// File: rtl/lipsi_ctrl.sv
// Multicycle fetch/decode/execute controller for the 8-bit Lipsi accumulator datapath.
// Optional build macro LIPSI_CTRL_ILLEGAL_TRAP_EN: undefined opcodes halt and set illegal.
module lipsi_ctrl #(
    parameter int          PC_W     = 8,
    parameter logic [7:0]  REG_BASE = 8'h00
) (
    input  logic          i_clk,
    input  logic          i_reset,
    lipsi_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_OPND   = 3'd3,
        S_INDIR  = 3'd4,
        S_EXEC   = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        OP_ALU_REG,
        OP_ST,
        OP_LDIND,
        OP_ALU_IMM,
        OP_BRANCH,
        OP_EXIT,
        OP_UNDEF
    } op_class_t;

    function automatic op_class_t f_decode(input logic [7:0] op);
        if (!op[7])                 return OP_ALU_REG;
        if (op[7:4] == 4'b1000)     return OP_ST;
        if (op[7:4] == 4'b1010)     return OP_LDIND;
        if (op[7:3] == 5'b11000)    return OP_ALU_IMM;
        if (op[7:2] == 6'b110100)   return OP_BRANCH;
        if (op == 8'hFF)            return OP_EXIT;
        return OP_UNDEF;
    endfunction

    function automatic logic f_taken(input logic [1:0] cc, input logic z, input logic c);
        case (cc)
            2'b00:   return 1'b1;
            2'b01:   return z;
            2'b10:   return !z;
            default: return c;
        endcase
    endfunction

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [7:0]      r_ir;
    logic [7:0]      r_imm;

    op_class_t       w_dec_class;
    op_class_t       w_ir_class;
    logic [PC_W-1:0] w_pc_inc;
    logic [7:0]      w_reg_addr;
    logic [7:0]      w_dmem_addr;
    logic            w_dmem_re;
    logic            w_dmem_we;
    logic [1:0]      w_acc_sel;
    logic [2:0]      w_alu_op;

    // DECODE looks at the byte arriving from program memory; later states use the latched ir.
    assign w_dec_class = f_decode(bus.pmem_rdata);
    assign w_ir_class  = f_decode(r_ir);
    assign w_pc_inc    = r_pc + PC_W'(1);
    assign w_reg_addr  = REG_BASE | {4'h0, bus.pmem_rdata[3:0]};

`ifdef LIPSI_CTRL_ILLEGAL_TRAP_EN
    logic r_illegal;
`endif

    // NOTE: every state-holding assignment here is non-blocking so all registers
    // update together from pre-edge values, whatever order the statements are in.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
            r_imm   <= '0;
`ifdef LIPSI_CTRL_ILLEGAL_TRAP_EN
            r_illegal <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_pc    <= '0;
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_pc    <= w_pc_inc;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_ir <= bus.pmem_rdata;
                    case (w_dec_class)
                        OP_ALU_REG:             r_state <= S_EXEC;
                        OP_ST:                  r_state <= S_FETCH;
                        OP_LDIND:               r_state <= S_INDIR;
                        OP_ALU_IMM, OP_BRANCH:  r_state <= S_OPND;
                        OP_EXIT:                r_state <= S_HALT;
                        default: begin
`ifdef LIPSI_CTRL_ILLEGAL_TRAP_EN
                            r_state   <= S_HALT;
                            r_illegal <= 1'b1;
`else
                            r_state <= S_FETCH;
`endif
                        end
                    endcase
                end
                S_OPND: begin
                    r_imm <= bus.pmem_rdata;
                    if (w_ir_class == OP_BRANCH) begin
                        // A taken branch replaces the increment past the operand byte.
                        if (f_taken(r_ir[1:0], bus.acc_zero, bus.carry))
                            r_pc <= PC_W'(bus.pmem_rdata);
                        else
                            r_pc <= w_pc_inc;
                        r_state <= S_FETCH;
                    end else begin
                        r_pc    <= w_pc_inc;
                        r_state <= S_EXEC;
                    end
                end
                S_INDIR: r_state <= S_EXEC;
                S_EXEC:  r_state <= S_FETCH;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_dmem_addr = '0;
        w_dmem_re   = 1'b0;
        w_dmem_we   = 1'b0;
        case (r_state)
            S_DECODE: begin
                case (w_dec_class)
                    OP_ALU_REG, OP_LDIND: begin
                        w_dmem_addr = w_reg_addr;
                        w_dmem_re   = 1'b1;
                    end
                    OP_ST: begin
                        w_dmem_addr = w_reg_addr;
                        w_dmem_we   = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_INDIR: begin
                w_dmem_addr = bus.dmem_rdata;
                w_dmem_re   = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_acc_sel = 2'b00;
        if (r_state == S_EXEC && w_ir_class != OP_LDIND)
            w_acc_sel = 2'b10;
    end

    always_comb begin
        w_alu_op = 3'd0;
        if (w_ir_class == OP_ALU_REG)
            w_alu_op = r_ir[6:4];
        else if (w_ir_class == OP_ALU_IMM)
            w_alu_op = r_ir[2:0];
    end

    assign bus.pmem_addr = r_pc;
    assign bus.dmem_addr = w_dmem_addr;
    assign bus.dmem_re   = w_dmem_re;
    assign bus.dmem_we   = w_dmem_we;
    assign bus.imm       = r_imm;
    assign bus.alu_op    = w_alu_op;
    assign bus.acc_sel   = w_acc_sel;
    assign bus.acc_we    = (r_state == S_EXEC);
    assign bus.carry_we  = (r_state == S_EXEC) && (w_acc_sel == 2'b10);
    assign bus.busy      = (r_state != S_IDLE) && (r_state != S_HALT);
    assign bus.halted    = (r_state == S_HALT);
`ifdef LIPSI_CTRL_ILLEGAL_TRAP_EN
    assign bus.illegal   = r_illegal;
`else
    assign bus.illegal   = 1'b0;
`endif

endmodule

// File: tb/tb_lipsi_ctrl.sv
// Directed bench for lipsi_ctrl: small program/data memory models and hand-computed
// per-cycle expectations for each instruction class.
module tb_lipsi_ctrl;

    logic clk;
    logic reset;
    logic [7:0] pmem [256];
    logic [7:0] dmem [256];
    int n_checks;
    int n_fail;

    lipsi_ctrl_if #(.PC_W(8)) bif ();

    lipsi_ctrl #(.PC_W(8), .REG_BASE(8'h00)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read memory models: data valid the cycle after the address.
    always @(posedge clk) begin
        bif.pmem_rdata <= pmem[bif.pmem_addr];
        if (bif.dmem_re)
            bif.dmem_rdata <= dmem[bif.dmem_addr];
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic clear_pmem();
        for (int i = 0; i < 256; i++) pmem[i] = 8'h00;
    endtask

    // Leaves the DUT in FETCH of address 0.
    task automatic go();
        bif.start = 1'b1;
        tick();
        bif.start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " pmem_addr"}, 32'(bif.pmem_addr), 32'h0);
        check({tag, " dmem_addr"}, 32'(bif.dmem_addr), 32'h0);
        check({tag, " dmem_re"},   32'(bif.dmem_re),   32'h0);
        check({tag, " dmem_we"},   32'(bif.dmem_we),   32'h0);
        check({tag, " imm"},       32'(bif.imm),       32'h0);
        check({tag, " alu_op"},    32'(bif.alu_op),    32'h0);
        check({tag, " acc_sel"},   32'(bif.acc_sel),   32'h0);
        check({tag, " acc_we"},    32'(bif.acc_we),    32'h0);
        check({tag, " carry_we"},  32'(bif.carry_we),  32'h0);
        check({tag, " busy"},      32'(bif.busy),      32'h0);
        check({tag, " halted"},    32'(bif.halted),    32'h0);
        check({tag, " illegal"},   32'(bif.illegal),   32'h0);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        reset        = 1'b1;
        bif.start    = 1'b0;
        bif.acc_zero = 1'b0;
        bif.carry    = 1'b0;
        clear_pmem();
        for (int i = 0; i < 256; i++) dmem[i] = 8'(i);
        tick();
        tick();
        reset = 1'b0;
        check_all_zero("reset");

        // add r3: FETCH, DECODE (read r3), EXEC
        pmem[0] = 8'h03;
        go();
        check("t1 fetch busy", 32'(bif.busy), 32'h1);
        check("t1 fetch pmem_addr", 32'(bif.pmem_addr), 32'h0);
        check("t1 fetch dmem_re", 32'(bif.dmem_re), 32'h0);
        tick();
        check("t1 dec dmem_addr", 32'(bif.dmem_addr), 32'h03);
        check("t1 dec dmem_re", 32'(bif.dmem_re), 32'h1);
        check("t1 dec dmem_we", 32'(bif.dmem_we), 32'h0);
        check("t1 dec acc_we", 32'(bif.acc_we), 32'h0);
        tick();
        check("t1 exec acc_we", 32'(bif.acc_we), 32'h1);
        check("t1 exec carry_we", 32'(bif.carry_we), 32'h1);
        check("t1 exec acc_sel", 32'(bif.acc_sel), 32'h2);
        check("t1 exec pc", 32'(bif.pmem_addr), 32'h01);
        tick();
        check("t1 next acc_we", 32'(bif.acc_we), 32'h0);
        check("t1 next pc", 32'(bif.pmem_addr), 32'h01);
        do_reset();

        // ALU imm op1 #5A, then exit
        clear_pmem();
        pmem[0] = 8'hC1; pmem[1] = 8'h5A; pmem[2] = 8'hFF;
        go();
        tick();
        check("t2 dec pmem_addr", 32'(bif.pmem_addr), 32'h01);
        check("t2 dec dmem_re", 32'(bif.dmem_re), 32'h0);
        tick();
        check("t2 opnd acc_we", 32'(bif.acc_we), 32'h0);
        check("t2 opnd busy", 32'(bif.busy), 32'h1);
        tick();
        check("t2 exec imm", 32'(bif.imm), 32'h5A);
        check("t2 exec alu_op", 32'(bif.alu_op), 32'h1);
        check("t2 exec acc_we", 32'(bif.acc_we), 32'h1);
        check("t2 exec acc_sel", 32'(bif.acc_sel), 32'h2);
        check("t2 exec pc", 32'(bif.pmem_addr), 32'h02);
        tick();
        tick();
        check("t5 dec halted", 32'(bif.halted), 32'h0);
        tick();
        check("t5 halted", 32'(bif.halted), 32'h1);
        check("t5 busy", 32'(bif.busy), 32'h0);
        bif.start = 1'b1;
        tick();
        tick();
        bif.start = 1'b0;
        check("t5 start ignored halted", 32'(bif.halted), 32'h1);
        check("t5 start ignored busy", 32'(bif.busy), 32'h0);
        check("t5 halt acc_we", 32'(bif.acc_we), 32'h0);
        check("t5 halt imm kept", 32'(bif.imm), 32'h5A);
        do_reset();
        check_all_zero("t5 reset");

        // Conditional branches: zero taken, zero not taken, carry taken
        clear_pmem();
        pmem[0] = 8'hD1; pmem[1] = 8'h10;
        bif.acc_zero = 1'b1;
        go(); tick(); tick(); tick();
        check("t3 bz taken pc", 32'(bif.pmem_addr), 32'h10);
        do_reset();
        bif.acc_zero = 1'b0;
        go(); tick(); tick(); tick();
        check("t3 bz not taken pc", 32'(bif.pmem_addr), 32'h02);
        do_reset();
        pmem[0] = 8'hD3; pmem[1] = 8'h77;
        bif.carry = 1'b1;
        go(); tick(); tick(); tick();
        check("t3 bc taken pc", 32'(bif.pmem_addr), 32'h77);
        bif.carry = 1'b0;
        do_reset();

        // Jump to FE, then a not-taken bnz at FE wraps pc FF -> 00
        clear_pmem();
        pmem[8'h00] = 8'hD0; pmem[8'h01] = 8'hFE;
        pmem[8'hFE] = 8'hD2; pmem[8'hFF] = 8'h40;
        bif.acc_zero = 1'b1;
        go(); tick(); tick(); tick();
        check("t3 jump pc", 32'(bif.pmem_addr), 32'hFE);
        tick();
        check("t3 dec at FE pc", 32'(bif.pmem_addr), 32'hFF);
        tick(); tick();
        check("t3 wrap pc", 32'(bif.pmem_addr), 32'h00);
        bif.acc_zero = 1'b0;
        do_reset();

        // ldind r2 with mem[02]=40
        clear_pmem();
        pmem[0] = 8'hA2;
        dmem[2] = 8'h40;
        go(); tick();
        check("t4 dec dmem_addr", 32'(bif.dmem_addr), 32'h02);
        check("t4 dec dmem_re", 32'(bif.dmem_re), 32'h1);
        tick();
        check("t4 indir dmem_addr", 32'(bif.dmem_addr), 32'h40);
        check("t4 indir dmem_re", 32'(bif.dmem_re), 32'h1);
        check("t4 indir acc_we", 32'(bif.acc_we), 32'h0);
        tick();
        check("t4 exec acc_sel", 32'(bif.acc_sel), 32'h0);
        check("t4 exec acc_we", 32'(bif.acc_we), 32'h1);
        check("t4 exec carry_we", 32'(bif.carry_we), 32'h0);
        do_reset();

        // st r5: two cycles, write strobe only
        clear_pmem();
        pmem[0] = 8'h85;
        go(); tick();
        check("st dmem_addr", 32'(bif.dmem_addr), 32'h05);
        check("st dmem_we", 32'(bif.dmem_we), 32'h1);
        check("st dmem_re", 32'(bif.dmem_re), 32'h0);
        tick();
        check("st next pc", 32'(bif.pmem_addr), 32'h01);
        check("st next dmem_we", 32'(bif.dmem_we), 32'h0);
        check("st next acc_we", 32'(bif.acc_we), 32'h0);
        do_reset();

        // Undefined opcode E0
        clear_pmem();
        pmem[0] = 8'hE0;
        go(); tick(); tick();
`ifdef LIPSI_CTRL_ILLEGAL_TRAP_EN
        check("t6 illegal", 32'(bif.illegal), 32'h1);
        check("t6 halted", 32'(bif.halted), 32'h1);
        check("t6 busy", 32'(bif.busy), 32'h0);
`else
        check("t6 illegal", 32'(bif.illegal), 32'h0);
        check("t6 nop busy", 32'(bif.busy), 32'h1);
        check("t6 nop pc", 32'(bif.pmem_addr), 32'h01);
        check("t6 nop acc_we", 32'(bif.acc_we), 32'h0);
`endif
        do_reset();
        check("t6 reset illegal", 32'(bif.illegal), 32'h0);

        // Reset in DECODE of an ALU op: EXEC never happens
        clear_pmem();
        pmem[0] = 8'h03;
        go(); tick();
        check("t6 pre-reset dmem_re", 32'(bif.dmem_re), 32'h1);
        do_reset();
        check("t6 abort acc_we", 32'(bif.acc_we), 32'h0);
        check("t6 abort busy", 32'(bif.busy), 32'h0);
        tick();
        check("t6 abort idle acc_we", 32'(bif.acc_we), 32'h0);
        check("t6 abort idle carry_we", 32'(bif.carry_we), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
